// File: rtl/efpga_prog_loader.sv
// efpga_prog_loader: replays header-framed stream words onto the eFPGA prog_i/prog_shft
// programming interface, with optional strobe pacing and sticky done/err status.
module efpga_prog_loader #(
  parameter int DW = 32,
  parameter int CHAINS = 7,
  parameter int GAP = 0,
  parameter logic [7:0] MAGIC = 8'hA5
) (
  input  logic              clk,
  input  logic              nres,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  input  logic              abort,
  output logic [DW-1:0]     prog_i,
  output logic [CHAINS-1:0] prog_shft,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int GW = GAP > 0 ? $clog2(GAP + 1) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, ERR} state_t;
  state_t            state;
  logic [CHAINS-1:0] mask;
  logic              last;
  logic [15:0]       remaining;
  logic [GW-1:0]     gap_cnt;
  logic              fire, hdr_ok;
  assign s_ready = !abort && (state == IDLE || (state == LOAD && gap_cnt == '0));
  assign fire    = s_valid && s_ready;
  assign hdr_ok  = s_data[31:24] == MAGIC && s_data[16 +: CHAINS] != '0 && s_data[15:0] != '0;
  assign busy    = state == LOAD;
  // prog_shft is a one-cycle strobe; the gap counter runs down regardless of s_valid
  always_ff @(posedge clk or negedge nres)
    if (!nres) begin
      state     <= IDLE;
      mask      <= '0;
      last      <= 1'b0;
      remaining <= '0;
      gap_cnt   <= '0;
      prog_i    <= '0;
      prog_shft <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      prog_shft <= '0;
      gap_cnt   <= gap_cnt == '0 ? '0 : gap_cnt - GW'(1);
      if (abort) begin
        state     <= IDLE;
        remaining <= '0;
        err       <= 1'b0;
      end else if (fire && state == IDLE) begin
        state     <= hdr_ok ? LOAD : ERR;
        err       <= !hdr_ok;
        mask      <= s_data[16 +: CHAINS];
        last      <= s_data[23];
        remaining <= s_data[15:0];
        if (hdr_ok) done <= 1'b0;
      end else if (fire) begin
        prog_i    <= s_data;
        prog_shft <= mask;
        remaining <= remaining - 16'd1;
        gap_cnt   <= GW'(GAP);
        if (remaining == 16'd1) begin
          state <= IDLE;
          done  <= last;
        end
      end
    end
endmodule

// File: tb/tb_efpga_prog_loader.sv
// tb_efpga_prog_loader: table-driven directed vectors for the loader, GAP=0 and GAP=2 instances.
module tb_efpga_prog_loader;
  logic clk = 1'b0, nres = 1'b0;
  always #5 clk = ~clk;
  logic v0 = 1'b0, a0 = 1'b0, r0, b0, dn0, e0;
  logic [31:0] d0 = '0, p0;
  logic [6:0] s0;
  logic v2 = 1'b0, a2 = 1'b0, r2, b2, dn2, e2;
  logic [31:0] d2 = '0, p2;
  logic [6:0] s2;
  efpga_prog_loader #(.GAP(0)) dut0 (.clk(clk), .nres(nres), .s_valid(v0), .s_ready(r0), .s_data(d0),
    .abort(a0), .prog_i(p0), .prog_shft(s0), .busy(b0), .done(dn0), .err(e0));
  efpga_prog_loader #(.GAP(2)) dut2 (.clk(clk), .nres(nres), .s_valid(v2), .s_ready(r2), .s_data(d2),
    .abort(a2), .prog_i(p2), .prog_shft(s2), .busy(b2), .done(dn2), .err(e2));
  typedef struct {
    logic v; logic [31:0] d; logic ab;
    logic rdy; logic [6:0] shft; logic [31:0] pi; logic busy, done, err;
  } vec_t;
  int n_chk = 0, n_fail = 0;
  vec_t t0[21];
  vec_t tg[6];
  function automatic vec_t mk(logic v, logic [31:0] d, logic ab, logic rdy, logic [6:0] shft,
                              logic [31:0] pi, logic busy, logic done, logic err);
    mk = '{v, d, ab, rdy, shft, pi, busy, done, err};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_out(input string tag, input logic g, input vec_t x);
    chk({tag, ".shft"}, 32'(g ? s2 : s0), 32'(x.shft));
    chk({tag, ".prog_i"}, g ? p2 : p0, x.pi);
    chk({tag, ".busy"}, 32'(g ? b2 : b0), 32'(x.busy));
    chk({tag, ".done"}, 32'(g ? dn2 : dn0), 32'(x.done));
    chk({tag, ".err"}, 32'(g ? e2 : e0), 32'(x.err));
  endtask
  task automatic run(input string tag, input logic g, input vec_t x);
    if (g) begin v2 = x.v; d2 = x.d; a2 = x.ab; end
    else begin v0 = x.v; d0 = x.d; a0 = x.ab; end
    #2;
    chk({tag, ".ready"}, 32'(g ? r2 : r0), 32'(x.rdy));
    @(posedge clk);
    #1;
    chk_out(tag, g, x);
    v0 = 1'b0; a0 = 1'b0; v2 = 1'b0; a2 = 1'b0;
  endtask
  initial begin
    // frame with LAST, mask 3, three payloads back-to-back
    t0[0]  = mk(1, 32'hA5830003, 0, 1, 7'h00, 32'h00, 1, 0, 0);
    t0[1]  = mk(1, 32'h00000011, 0, 1, 7'h03, 32'h11, 1, 0, 0);
    t0[2]  = mk(1, 32'h00000022, 0, 1, 7'h03, 32'h22, 1, 0, 0);
    t0[3]  = mk(1, 32'h00000033, 0, 1, 7'h03, 32'h33, 0, 1, 0);
    t0[4]  = mk(0, 32'h0, 0, 1, 7'h00, 32'h33, 0, 1, 0);
    // bad tag, ERR holds, abort recovers, next header accepted and clears done
    t0[5]  = mk(1, 32'h5A010001, 0, 1, 7'h00, 32'h33, 0, 1, 1);
    t0[6]  = mk(1, 32'hA5010001, 0, 0, 7'h00, 32'h33, 0, 1, 1);
    t0[7]  = mk(1, 32'hA5010001, 1, 0, 7'h00, 32'h33, 0, 1, 0);
    t0[8]  = mk(1, 32'hA5010001, 0, 1, 7'h00, 32'h33, 1, 0, 0);
    t0[9]  = mk(1, 32'h00000044, 0, 1, 7'h01, 32'h44, 0, 0, 0);
    // mask 0 and N=0 are errors
    t0[10] = mk(1, 32'hA5000004, 0, 1, 7'h00, 32'h44, 0, 0, 1);
    t0[11] = mk(0, 32'h0, 1, 0, 7'h00, 32'h44, 0, 0, 0);
    t0[12] = mk(1, 32'hA5010000, 0, 1, 7'h00, 32'h44, 0, 0, 1);
    t0[13] = mk(0, 32'h0, 1, 0, 7'h00, 32'h44, 0, 0, 0);
    // abort after 2 of 5 payloads; following word is a header
    t0[14] = mk(1, 32'hA5020005, 0, 1, 7'h00, 32'h44, 1, 0, 0);
    t0[15] = mk(1, 32'h00000055, 0, 1, 7'h02, 32'h55, 1, 0, 0);
    t0[16] = mk(1, 32'h00000066, 0, 1, 7'h02, 32'h66, 1, 0, 0);
    t0[17] = mk(1, 32'h00000077, 1, 0, 7'h00, 32'h66, 0, 0, 0);
    t0[18] = mk(1, 32'hA5890001, 0, 1, 7'h00, 32'h66, 1, 0, 0);
    t0[19] = mk(1, 32'h00000088, 0, 1, 7'h09, 32'h88, 0, 1, 0);
    t0[20] = mk(0, 32'h0, 1, 0, 7'h00, 32'h88, 0, 1, 0);
    // GAP=2 instance, s_valid held high through the gaps
    tg[0]  = mk(1, 32'hA5010002, 0, 1, 7'h00, 32'h00, 1, 0, 0);
    tg[1]  = mk(1, 32'h000000A1, 0, 1, 7'h01, 32'hA1, 1, 0, 0);
    tg[2]  = mk(1, 32'h000000A2, 0, 0, 7'h00, 32'hA1, 1, 0, 0);
    tg[3]  = mk(1, 32'h000000A2, 0, 0, 7'h00, 32'hA1, 1, 0, 0);
    tg[4]  = mk(1, 32'h000000A2, 0, 1, 7'h01, 32'hA2, 0, 0, 0);
    tg[5]  = mk(0, 32'h0, 0, 1, 7'h00, 32'hA2, 0, 0, 0);
    #3;
    chk("rst.ready", 32'(r0), 32'd1);
    chk_out("rst", 1'b0, mk(0, 0, 0, 1, 7'h00, 32'h0, 0, 0, 0));
    chk_out("rst2", 1'b1, mk(0, 0, 0, 1, 7'h00, 32'h0, 0, 0, 0));
    @(negedge clk) nres = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 21; i++) run($sformatf("v%0d", i), 1'b0, t0[i]);
    for (int i = 0; i < 6; i++) run($sformatf("gap%0d", i), 1'b1, tg[i]);
    // asynchronous reset in the middle of a frame
    run("ar0", 1'b0, mk(1, 32'hA5830002, 0, 1, 7'h00, 32'h88, 1, 0, 0));
    run("ar1", 1'b0, mk(1, 32'h00000099, 0, 1, 7'h03, 32'h99, 1, 0, 0));
    #1 nres = 1'b0;
    #1;
    chk_out("arst", 1'b0, mk(0, 0, 0, 1, 7'h00, 32'h0, 0, 0, 0));
    v0 = 1'b1; d0 = 32'hA5810001;
    repeat (2) @(posedge clk);
    #1;
    chk_out("arst_hold", 1'b0, mk(0, 0, 0, 1, 7'h00, 32'h0, 0, 0, 0));
    v0 = 1'b0;
    @(negedge clk) nres = 1'b1;
    @(posedge clk);
    #1;
    run("ar2", 1'b0, mk(1, 32'hA5810001, 0, 1, 7'h00, 32'h0, 1, 0, 0));
    run("ar3", 1'b0, mk(1, 32'h000000BB, 0, 1, 7'h01, 32'hBB, 0, 1, 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
